i2c_reg_target: RTL

//   I2C target (slave) front end of the dice design. Takes raw SCL/SDA pads
//   (uio_in[2]/uio_in[1]), decodes START/STOP, address, sub-address and data

---
 rtl/i2c_reg_target.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_reg_target.sv
// I2C target front end: synchronises raw SCL/SDA, decodes START/STOP,
// address, sub-address and data bytes, and drives a byte-wide register-file
// port with auto-incrementing pointer on both writes and reads.
// SDA is open drain: sda_oe=1 pulls the line low, the block never drives high.
module i2c_reg_target #(
  parameter logic [6:0]  I2C_ADDR = 7'h70,
  parameter int unsigned ADDR_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy
);

  typedef enum logic [3:0] {
    ST_IDLE,      // waiting for START
    ST_ADDR,      // shifting in the address byte
    ST_ACK_A,     // pulling SDA for the address ACK
    ST_SUB,       // shifting in the sub-address byte
    ST_ACK_S,     // pulling SDA for the sub-address ACK
    ST_WR,        // shifting in a write data byte
    ST_ACK_W,     // pulling SDA for the data ACK
    ST_RD,        // driving a read byte out, MSB first
    ST_RACK,      // waiting for the master's ACK/NAK
    ST_IDLE_WAIT  // master NAKed; stay off the bus until STOP/START
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Synchroniser stages and one history flop per line
  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;

  // Bus events derived from synchronised values
  logic scl_rise, scl_fall, start_evt, stop_evt;

  // Registered state and next-state values
  state_t              state, state_d;
  logic [3:0]          bit_cnt, bit_cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic [7:0]          tx_q, tx_d;
  logic                sda_oe_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [7:0]          wdata_d;
  logic                we_d, re_d, busy_d;
  logic                shifting;

  // Two-flop synchroniser plus history flop on both pads
  // NOTE: synchroniser flops reset to 1 (idle bus level) so releasing reset
  // never manufactures a false SCL edge or START/STOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make each flop sample the previous
      // stage's old value, which is what builds the shift chain.
      scl_s1 <= scl_in;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda_in;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  // Edge and START/STOP decode on the synchronised lines
  always_comb begin
    scl_rise  = scl_s2 & ~scl_d;
    scl_fall  = ~scl_s2 & scl_d;
    start_evt = scl_s2 & scl_d & sda_d & ~sda_s2;
    stop_evt  = scl_s2 & scl_d & ~sda_d & sda_s2;
  end

  // States in which SCL rises clock a bit into the shift register / bit count
  always_comb begin
    shifting = (state == ST_ADDR) || (state == ST_SUB) ||
               (state == ST_WR)   || (state == ST_RD);
  end

  // Next-state and registered-output logic
  // NOTE: every variable gets a default before the case, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    shift_d   = shift_q;
    tx_d      = tx_q;
    sda_oe_d  = sda_oe;
    addr_d    = reg_addr;
    wdata_d   = reg_wdata;
    we_d      = 1'b0;
    re_d      = 1'b0;
    busy_d    = busy;

    // Pointer advances the cycle after each write strobe
    if (reg_we) addr_d = reg_addr + ADDR_ONE;

    // Data is sampled on SCL rise; the count saturates at a full byte
    if (scl_rise && shifting && (bit_cnt < 4'd8)) begin
      shift_d   = {shift_q[6:0], sda_s2};
      bit_cnt_d = bit_cnt + 4'd1;
    end

    unique case (state)
      ST_ADDR: begin
        if (scl_fall && (bit_cnt == 4'd8)) begin
          if (shift_q[7:1] == I2C_ADDR) begin
            state_d  = ST_ACK_A;
            sda_oe_d = 1'b1;
            busy_d   = 1'b1;
          end else begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
          end
        end
      end

      ST_ACK_A: begin
        // shift_q[0] still holds R/W: nothing shifts during the ACK slot
        if (scl_fall) begin
          bit_cnt_d = 4'd0;
          if (shift_q[0]) begin
            tx_d     = reg_rdata;
            re_d     = 1'b1;
            sda_oe_d = ~reg_rdata[7];
            state_d  = ST_RD;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = ST_SUB;
          end
        end
      end

      ST_SUB: begin
        if (scl_fall && (bit_cnt == 4'd8)) begin
          addr_d   = shift_q[ADDR_W-1:0];
          sda_oe_d = 1'b1;
          state_d  = ST_ACK_S;
        end
      end

      ST_ACK_S, ST_ACK_W: begin
        if (scl_fall) begin
          sda_oe_d  = 1'b0;
          bit_cnt_d = 4'd0;
          state_d   = ST_WR;
        end
      end

      ST_WR: begin
        if (scl_fall && (bit_cnt == 4'd8)) begin
          wdata_d  = shift_q;
          we_d     = 1'b1;
          sda_oe_d = 1'b1;
          state_d  = ST_ACK_W;
        end
      end

      ST_RD: begin
        if (scl_fall) begin
          if (bit_cnt == 4'd8) begin
            sda_oe_d = 1'b0;
            state_d  = ST_RACK;
          end else begin
            sda_oe_d = ~tx_q[3'd7 - bit_cnt[2:0]];
          end
        end
      end

      ST_RACK: begin
        // Pointer moves on the ACK rise so reg_rdata is settled by the fall
        if (scl_rise) begin
          if (!sda_s2) addr_d  = reg_addr + ADDR_ONE;
          else         state_d = ST_IDLE_WAIT;
        end else if (scl_fall) begin
          tx_d      = reg_rdata;
          re_d      = 1'b1;
          sda_oe_d  = ~reg_rdata[7];
          bit_cnt_d = 4'd0;
          state_d   = ST_RD;
        end
      end

      default: ;  // ST_IDLE, ST_IDLE_WAIT: only START/STOP matter
    endcase

    // START/STOP abort anything in flight; a truncated byte never strobes
    if (start_evt) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      we_d      = 1'b0;
      re_d      = 1'b0;
    end else if (stop_evt) begin
      state_d   = ST_IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      we_d      = 1'b0;
      re_d      = 1'b0;
    end
  end

  // State register; async reset also releases SDA immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= 4'd0;
      shift_q   <= 8'h00;
      tx_q      <= 8'h00;
      sda_oe    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= 8'h00;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      bit_cnt   <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      sda_oe    <= sda_oe_d;
      reg_addr  <= addr_d;
      reg_wdata <= wdata_d;
      reg_we    <= we_d;
      reg_re    <= re_d;
      busy      <= busy_d;
    end
  end

endmodule
